// File: rtl/ring_buffer_v2.sv
// Single-clock show-ahead ring buffer queue with occupancy count, programmable
// almost-full/almost-empty flags, synchronous flush and optional overwrite of the oldest entry.
// Sticky overflow/underflow flags exist only when RING_BUFFER_ERR_FLAGS_EN is defined.
module ring_buffer_v2 #(
    parameter int WIDTH        = 8,
    parameter int LENGTH       = 5,
    parameter int OVERWRITABLE = 0,
    parameter int AFULL_TH     = LENGTH - 1,
    parameter int AEMPTY_TH    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       enqueue_i,
    input  logic                       dequeue_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(LENGTH+1)-1:0] count_o,
    output logic                       dropped_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int CW = $clog2(LENGTH + 1);
    localparam int PW = $clog2(LENGTH);
    localparam logic [CW-1:0] LENGTH_C  = CW'(LENGTH);
    localparam logic [CW-1:0] AFULL_C   = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C  = CW'(AEMPTY_TH);
    localparam logic [PW-1:0] PTR_MAX   = PW'(LENGTH - 1);
    localparam logic          OVW       = (OVERWRITABLE != 0);

    logic [WIDTH-1:0] mem_q [LENGTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             dropped_q, dropped_d;
    logic             push_ok, pop_ok, overwrite;

    // Pointers wrap by explicit compare so any LENGTH >= 2 is legal.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    // Handshake: enqueue_i/dequeue_i are single-cycle requests with no back-pressure;
    // a request is consumed at the edge when push_ok/pop_ok hold, otherwise it is dropped.
    assign push_ok   = enqueue_i & (~full | OVW | dequeue_i);
    assign pop_ok    = dequeue_i & ~empty;
    assign overwrite = push_ok & full & ~dequeue_i;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dropped_d = 1'b0;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_ok || overwrite) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push_ok && !pop_ok && !full) begin
                count_d = count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 1'b1;
            end
            dropped_d = overwrite;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            dropped_q <= dropped_d;
        end
    end

    // Storage is not reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i && !rst) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign full         = (count_q == LENGTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count_o      = count_q;
    assign dropped_o    = dropped_q;
    assign data_o       = empty ? '0 : mem_q[rd_ptr_q];

`ifdef RING_BUFFER_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q | (full & enqueue_i & ~dequeue_i & ~OVW);
        underflow_d = underflow_q | (dequeue_i & empty);
        if (flush_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_ring_buffer_v2.sv
// Directed bench for ring_buffer_v2: table-driven vectors on a LENGTH=5 queue, plus
// hand-written overwrite (OVERWRITABLE=1) and non-power-of-two wrap (LENGTH=3) sequences.
module tb_ring_buffer_v2;

`ifdef RING_BUFFER_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance 0: LENGTH=5, OVERWRITABLE=0
    logic       rst0, fl0, enq0, deq0;
    logic [7:0] din0, dout0;
    logic [2:0] cnt0;
    logic       full0, empty0, af0, ae0, drop0, ovf0, udf0;
    // instance 1: LENGTH=5, OVERWRITABLE=1
    logic       rst1, fl1, enq1, deq1;
    logic [7:0] din1, dout1;
    logic [2:0] cnt1;
    logic       full1, empty1, af1, ae1, drop1, ovf1, udf1;
    // instance 2: LENGTH=3, OVERWRITABLE=0
    logic       rst2, fl2, enq2, deq2;
    logic [7:0] din2, dout2;
    logic [1:0] cnt2;
    logic       full2, empty2, af2, ae2, drop2, ovf2, udf2;

    ring_buffer_v2 #(.WIDTH(8), .LENGTH(5), .OVERWRITABLE(0), .AFULL_TH(4), .AEMPTY_TH(1)) u_dut0 (
        .clk(clk), .rst(rst0), .flush_i(fl0), .enqueue_i(enq0), .dequeue_i(deq0),
        .data_i(din0), .data_o(dout0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count_o(cnt0),
        .dropped_o(drop0), .overflow_o(ovf0), .underflow_o(udf0));

    ring_buffer_v2 #(.WIDTH(8), .LENGTH(5), .OVERWRITABLE(1), .AFULL_TH(4), .AEMPTY_TH(1)) u_dut1 (
        .clk(clk), .rst(rst1), .flush_i(fl1), .enqueue_i(enq1), .dequeue_i(deq1),
        .data_i(din1), .data_o(dout1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count_o(cnt1),
        .dropped_o(drop1), .overflow_o(ovf1), .underflow_o(udf1));

    ring_buffer_v2 #(.WIDTH(8), .LENGTH(3), .OVERWRITABLE(0), .AFULL_TH(2), .AEMPTY_TH(1)) u_dut2 (
        .clk(clk), .rst(rst2), .flush_i(fl2), .enqueue_i(enq2), .dequeue_i(deq2),
        .data_i(din2), .data_o(dout2), .full(full2), .empty(empty2),
        .almost_full(af2), .almost_empty(ae2), .count_o(cnt2),
        .dropped_o(drop2), .overflow_o(ovf2), .underflow_o(udf2));

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    // flags = {full, empty, almost_full, almost_empty, dropped, overflow, underflow}
    typedef struct {
        logic       rst, fl, enq, deq;
        logic [7:0] din;
        logic [7:0] e_data;
        logic [2:0] e_cnt;
        logic [6:0] e_flags;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic f, input logic e, input logic d,
                                input logic [7:0] di, input logic [7:0] ed, input logic [2:0] ec,
                                input logic [6:0] ef);
        vec_t v;
        v.rst = r; v.fl = f; v.enq = e; v.deq = d; v.din = di;
        v.e_data = ed; v.e_cnt = ec; v.e_flags = ef;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic run_table();
        foreach (vecs[k]) begin
            rst0 = vecs[k].rst; fl0 = vecs[k].fl; enq0 = vecs[k].enq; deq0 = vecs[k].deq;
            din0 = vecs[k].din;
            step();
            chk($sformatf("v%0d_data", k), 32'(dout0), 32'(vecs[k].e_data));
            chk($sformatf("v%0d_count", k), 32'(cnt0), 32'(vecs[k].e_cnt));
            chk($sformatf("v%0d_flags", k), 32'({full0, empty0, af0, ae0, drop0, ovf0, udf0}),
                32'(vecs[k].e_flags));
        end
        rst0 = 1'b0; fl0 = 1'b0; enq0 = 1'b0; deq0 = 1'b0;
    endtask

    task automatic run_overwrite();
        exp_q.delete();
        rst1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            enq1 = 1'b1; din1 = 8'h61 + 8'(k);
            step();
            exp_q.push_back(8'h61 + 8'(k));
            if (exp_q.size() > 5) void'(exp_q.pop_front());
            chk($sformatf("ovw_drop%0d", k), 32'(drop1), 32'(k >= 5));
            chk($sformatf("ovw_cnt%0d", k), 32'(cnt1), (k < 5) ? 32'(k + 1) : 32'd5);
        end
        enq1 = 1'b0;
        chk("ovw_head_is_d", 32'(dout1), 32'h64);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("ovw_drain%0d", k), 32'(dout1), 32'(exp_q[0]));
            deq1 = 1'b1;
            step();
            void'(exp_q.pop_front());
            chk($sformatf("ovw_drop_clr%0d", k), 32'(drop1), 32'd0);
        end
        deq1 = 1'b0;
        chk("ovw_empty", 32'(empty1), 32'd1);
    endtask

    task automatic run_wrap();
        exp_q.delete();
        rst2 = 1'b0;
        for (int v = 0; v < 3; v++) begin
            enq2 = 1'b1; din2 = 8'(v);
            step();
            exp_q.push_back(8'(v));
            chk($sformatf("wrap_fill_data%0d", v), 32'(dout2), 32'(exp_q[0]));
            chk($sformatf("wrap_fill_cnt%0d", v), 32'(cnt2), 32'(exp_q.size()));
        end
        chk("wrap_full", 32'(full2), 32'd1);
        for (int v = 3; v < 10; v++) begin
            enq2 = 1'b1; deq2 = 1'b1; din2 = 8'(v);
            step();
            void'(exp_q.pop_front());
            exp_q.push_back(8'(v));
            chk($sformatf("wrap_pair_data%0d", v), 32'(dout2), 32'(exp_q[0]));
            chk($sformatf("wrap_pair_cnt%0d", v), 32'(cnt2), 32'd3);
        end
        enq2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            void'(exp_q.pop_front());
            chk($sformatf("wrap_drain_data%0d", k), 32'(dout2),
                (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
            chk($sformatf("wrap_drain_cnt%0d", k), 32'(cnt2), 32'(exp_q.size()));
        end
        deq2 = 1'b0;
        chk("wrap_empty", 32'(empty2), 32'd1);
    endtask

    // ---------------- test ----------------
    initial begin
        logic [2:0] c;
        rst0 = 1'b1; fl0 = 1'b0; enq0 = 1'b0; deq0 = 1'b0; din0 = '0;
        rst1 = 1'b1; fl1 = 1'b0; enq1 = 1'b0; deq1 = 1'b0; din1 = '0;
        rst2 = 1'b1; fl2 = 1'b0; enq2 = 1'b0; deq2 = 1'b0; din2 = '0;

        // reset, 2 cycles
        for (int i = 0; i < 2; i++) add(1, 0, 0, 0, 8'h00, 8'h00, 3'd0, 7'b0101000);
        // fill with 'a'..'p'; overflow from the 6th push onward
        for (int i = 0; i < 16; i++) begin
            c = (i < 5) ? 3'(i + 1) : 3'd5;
            add(0, 0, 1, 0, 8'h61 + 8'(i), 8'h61, c,
                {i >= 4, 1'b0, i >= 3, i == 0, 1'b0, ERR_EN & (i >= 5), 1'b0});
        end
        // drain 16 cycles: head goes b,c,d,e then 0
        for (int j = 0; j < 16; j++) begin
            c = (j < 4) ? 3'(4 - j) : 3'd0;
            add(0, 0, 0, 1, 8'h00, (j < 4) ? 8'h62 + 8'(j) : 8'h00, c,
                {1'b0, j >= 4, j == 0, j >= 3, 1'b0, ERR_EN, ERR_EN & (j >= 5)});
        end
        // flush clears sticky flags
        add(0, 1, 0, 0, 8'h00, 8'h00, 3'd0, 7'b0101000);
        // enqueue+dequeue on empty
        add(0, 0, 1, 1, 8'h11, 8'h11, 3'd1, {6'b000100, ERR_EN});
        add(0, 0, 1, 0, 8'h22, 8'h11, 3'd2, {6'b000000, ERR_EN});
        add(0, 0, 1, 0, 8'h33, 8'h11, 3'd3, {6'b000000, ERR_EN});
        add(0, 0, 1, 0, 8'h44, 8'h11, 3'd4, {6'b001000, ERR_EN});
        add(0, 0, 1, 0, 8'h55, 8'h11, 3'd5, {6'b101000, ERR_EN});
        // enqueue+dequeue on full: no overflow, order kept
        add(0, 0, 1, 1, 8'h66, 8'h22, 3'd5, {6'b101000, ERR_EN});
        add(0, 0, 0, 1, 8'h00, 8'h33, 3'd4, {6'b001000, ERR_EN});
        add(0, 0, 0, 1, 8'h00, 8'h44, 3'd3, {6'b000000, ERR_EN});
        // flush with 3 entries beats the enqueue
        add(0, 1, 1, 0, 8'h77, 8'h00, 3'd0, 7'b0101000);
        add(0, 0, 1, 0, 8'h01, 8'h01, 3'd1, 7'b0001000);
        add(0, 0, 1, 0, 8'h02, 8'h01, 3'd2, 7'b0000000);
        add(0, 0, 1, 0, 8'h03, 8'h01, 3'd3, 7'b0000000);
        add(0, 0, 1, 0, 8'h04, 8'h01, 3'd4, 7'b0010000);
        // reset mid-stream with dequeue held
        add(1, 0, 0, 1, 8'h00, 8'h00, 3'd0, 7'b0101000);
        add(0, 0, 1, 0, 8'h5A, 8'h5A, 3'd1, 7'b0001000);
        add(0, 0, 0, 1, 8'h00, 8'h00, 3'd0, 7'b0101000);

        #1;
        run_table();
        run_overwrite();
        run_wrap();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
